// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer driving one external full-adder cell, LSB first.
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the sub input port.
module serial_adder_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] PEN  = CNT_W'(WIDTH - 2);

   state_t           state;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             carry_q, cin_msb;
   logic [CNT_W-1:0] cnt;
   logic             sub_i;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_i = sub;
`else
   assign sub_i = 1'b0;
`endif

   // busy is registered and equals (state == RUN), so it gates the cell inputs
   assign fa_a   = busy & a_sh[0];
   assign fa_b   = busy & b_sh[0];
   assign fa_cin = busy & carry_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         carryout <= 1'b0;
         overflow <= 1'b0;
         a_sh     <= '0;
         b_sh     <= '0;
         carry_q  <= 1'b0;
         cin_msb  <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  // subtract is a + ~b + 1: invert b and seed the carry
                  a_sh     <= a;
                  b_sh     <= sub_i ? ~b : b;
                  carry_q  <= sub_i;
                  cnt      <= '0;
                  sum      <= '0;
                  carryout <= 1'b0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               sum     <= {fa_sum, sum[WIDTH-1:1]};
               carry_q <= fa_cout;
               cnt     <= cnt + 1'b1;
               if (cnt == PEN) cin_msb <= fa_cout;
               if (cnt == LAST) begin
                  carryout <= fa_cout;
                  overflow <= cin_msb ^ fa_cout;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a behavioural full-adder cell and a result scoreboard.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, carryout, overflow;
   logic [W-1:0] sum;
   logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;

   int checks = 0;
   int errors = 0;

   logic [W+1:0] q[$];
   logic [W-1:0] op_a, op_b, op_c;

   always #5 clk = ~clk;

   assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   serial_adder_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .a(a), .b(b), .busy(busy), .done(done), .sum(sum),
      .carryout(carryout), .overflow(overflow),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
      .fa_sum(fa_sum), .fa_cout(fa_cout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one request and records its expected outcome; keep leaves start high.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub, input bit keep);
      logic [W-1:0] bb;
      logic [W:0]   full;
      logic         c, ovf;
      bb = isub ? ~ib : ib;
      c  = isub;
      for (int i = 0; i < W; i++) begin
         op_c[i] = c;
         c = (ia[i] & bb[i]) | (ia[i] & c) | (bb[i] & c);
      end
      full = {1'b0, ia} + {1'b0, bb} + (W+1)'(isub);
      ovf  = (ia[W-1] == bb[W-1]) && (full[W-1] != ia[W-1]);
      op_a = ia;
      op_b = bb;
      q.push_back({ovf, full[W], full[W-1:0]});
      a = ia; b = ib; sub = isub; start = 1'b1;
      @(posedge clk); #1;
      if (!keep) start = 1'b0;
      chk("accept_busy", busy, 1'b1);
      chk("accept_sum_clear", sum, 0);
   endtask

   // pre = negedges already elapsed since the accept edge
   task automatic wait_done(input int pre);
      int n, k;
      bit got;
      logic [W+1:0] e;
      n = pre; k = pre; got = 0;
      while (!got && n < pre + 30) begin
         @(negedge clk);
         n++;
         if (busy === 1'b1) begin
            if (k < W) begin
               chk("fa_a", fa_a, op_a[k]);
               chk("fa_b", fa_b, op_b[k]);
               chk("fa_cin", fa_cin, op_c[k]);
            end
            k++;
         end
         if (done === 1'b1) got = 1;
      end
      chk("busy_cycles", k, W);
      chk("done_latency", n, W + 1);
      chk("result_pending", q.size(), 1);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("sum", sum, e[W-1:0]);
         chk("carryout", carryout, e[W]);
         chk("overflow", overflow, e[W+1]);
         chk("busy_at_done", busy, 1'b0);
      end
   endtask

   initial begin
      int spurious;
      // reset held two cycles
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sum", sum, 0);
      chk("rst_carryout", carryout, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_fa", {fa_a, fa_b, fa_cin}, 0);

      issue(8'h2A, 8'h15, 1'b0, 0); wait_done(0);
      @(negedge clk);
      chk("done_pulse_width", done, 1'b0);
      chk("sum_hold", sum, 8'h3F);

      issue(8'hFF, 8'h01, 1'b0, 0); wait_done(0);
      issue(8'h7F, 8'h01, 1'b0, 0); wait_done(0);

      // back-to-back: start held high, new operands presented in each DONE cycle
      issue(8'h10, 8'h20, 1'b0, 1); wait_done(0);
      issue(8'h33, 8'h44, 1'b0, 1); wait_done(0);
      issue(8'hC8, 8'h64, 1'b0, 0); wait_done(0);

      // start during RUN must be ignored
      issue(8'h5A, 8'h3C, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1; a = 8'h11; b = 8'h22; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_done(4);
      repeat (3) begin
         @(negedge clk);
         chk("no_queued_run", busy, 1'b0);
      end

      // reset at the fourth RUN edge discards the operation
      issue(8'hAA, 8'h54, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1; reset_n = 1'b0;
      @(posedge clk); #1; reset_n = 1'b1;
      q.delete();
      @(negedge clk);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_sum", sum, 0);
      chk("midrst_carryout", carryout, 1'b0);
      chk("midrst_overflow", overflow, 1'b0);
      spurious = 0;
      repeat (12) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) spurious++;
      end
      chk("midrst_no_done", spurious, 0);
      issue(8'hAA, 8'h54, 1'b0, 0); wait_done(0);

`ifdef SERIAL_ADDER_SUB_EN
      issue(8'h05, 8'h07, 1'b1, 0); wait_done(0);
      issue(8'h80, 8'h01, 1'b1, 0); wait_done(0);
      issue(8'h30, 8'h10, 1'b0, 0); wait_done(0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that performs a WIDTH-bit add on one external 1-bit full-adder cell (structuralFullAdder), one bit per clock, LSB first.
- Latches operands on a start handshake and drives the adder's a/b/carryin each cycle.
- Captures the adder's sum/carryout into a result shift register and a carry flop.
- Reports result, carry-out and signed overflow with a one-cycle done pulse.
- Sits between an operand producer and the shared full-adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when state is IDLE or DONE.
- a  input  WIDTH  operand A; sampled with an accepted start.
- b  input  WIDTH  operand B; sampled with an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; holds until the next accepted start.
- carryout  output  1  carry out of the MSB.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).
- fa_a  output  1  to the full adder's a input.
- fa_b  output  1  to the full adder's b input.
- fa_cin  output  1  to the full adder's carryin input.
- fa_sum  input  1  from the full adder's sum output.
- fa_cout  input  1  from the full adder's carryout output.

Behaviour:
- Reset (reset_n=0 at a rising edge): state=IDLE; busy, done, sum, carryout, overflow, carry flop and counter all 0. Reset wins over every other event, including mid-RUN; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE: fa_a/fa_b/fa_cin=0. If start=1: latch a into a_sh, b into b_sh, carry_q=0, cnt=0, sum cleared to 0; go to RUN.
- RUN: busy=1; fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_q. The full adder is purely combinational, so its outputs are valid in the same cycle. Each edge:
  - a_sh and b_sh shift right.
  - sum shifts right with fa_sum inserted at the MSB.
  - carry_q<=fa_cout and cnt++.
  - When cnt==WIDTH-2 at the edge, record cin_msb<=fa_cout; this is the carry into the MSB.
  - When cnt==WIDTH-1 at the edge: carryout<=fa_cout, overflow<=cin_msb^fa_cout, go to DONE.
- RUN, start: start is ignored; there is no queueing.
- DONE: done=1 for exactly this cycle; fa_* = 0. If start=1, the new operands are accepted exactly as in IDLE and the next state is RUN (back-to-back operation). Otherwise go to IDLE.
- Latency: start is accepted at edge E0. Bits are captured at edges E1..EWIDTH. done is high in the cycle following EWIDTH. Back-to-back throughput is one operation per WIDTH+1 cycles.
- Arithmetic: unsigned sum modulo 2^WIDTH; carryout is bit WIDTH of the true sum.
- Outputs sum, carryout and overflow are stable from the DONE cycle until the next accepted start. They are cleared at that accept.

Optional Feature:
- SERIAL_ADDER_SUB_EN defined: adds an input port sub (1 bit), sampled with an accepted start.
  - sub=1: b is latched as ~b and carry_q is initialised to 1, giving a-b in two's complement.
  - carryout=1 means no borrow. overflow uses the same rule as for addition.
  - sub=0: behaviour is identical to the base adder.
- SERIAL_ADDER_SUB_EN undefined: no sub port; the block adds only.

Test Plan:
- Reset held for 2 cycles -> busy=0, done=0, sum=8'h00, carryout=0, overflow=0.
- a=8'h2A, b=8'h15, start pulse -> busy for 8 cycles; done at cycle 9 after the accept; sum=8'h3F, carryout=0, overflow=0; fa_cin toggles only per the carry chain.
- a=8'hFF, b=8'h01 -> sum=8'h00, carryout=1, overflow=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, carryout=0, overflow=1.
- start held high continuously with new operands at each DONE -> back-to-back results every 9 cycles. A second start asserted mid-RUN (operands 8'h11/8'h22) is ignored and the first result is unaffected.
- reset_n=0 at the fourth RUN edge -> next cycle IDLE, all outputs 0, no done pulse. A new start afterwards yields the correct result for its operands.
- With SERIAL_ADDER_SUB_EN: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, carryout=0, overflow=0. Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, carryout=1, overflow=1.
